// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch timekeeping core.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W  = 5;
  localparam int unsigned ONES_MAX = 9;
  localparam int unsigned TENS_MAX = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD field counting 00..MAX_VAL; carry_out flags the wrap in the same cycle.
module bcd_mod60
  import stopwatch_pkg::*;
#(
  parameter int unsigned W       = stopwatch_pkg::DIGIT_W,
  parameter int unsigned MAX_VAL = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] tens,
  output logic [W-1:0] ones,
  output logic         carry_out
);

  localparam int unsigned TENS_TOP = MAX_VAL / 10;
  localparam int unsigned ONES_TOP = MAX_VAL % 10;

  logic at_top;

  assign at_top    = (tens == W'(TENS_TOP)) && (ones == W'(ONES_TOP));
  assign carry_out = inc && at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clear) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_top) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == W'(ONES_MAX)) begin
        ones <= '0;
        tens <= tens + W'(1);
      end else begin
        ones <= ones + W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: run/pause/adjust FSM steering increments into two BCD mod-60 fields.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGIT_W = stopwatch_pkg::DIGIT_W,
  parameter int unsigned MAX_VAL = 59
) (
  input  logic               clk,
  input  logic               btn_reset,
  input  logic               tick_1hz,
  input  logic               tick_adj,
  input  logic               btn_pause,
  input  logic               adj,
  input  logic [2:0]         adj_sel,
  output logic [DIGIT_W-1:0] min_l,
  output logic [DIGIT_W-1:0] min_r,
  output logic [DIGIT_W-1:0] sec_l,
  output logic [DIGIT_W-1:0] sec_r,
  output logic               running
);

  state_t state_q;
  state_t state_d;
  logic   sec_inc;
  logic   min_inc;
  logic   sec_carry;
  logic   min_carry;
  logic   unused_sel;

  assign unused_sel = ^adj_sel[2:1];

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state_q <= ST_PAUSE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == ST_RUN);
    end
  end

  // Adjust wins over pause; ticks are qualified by the current state, not the next.
  always_comb begin
    state_d = state_q;
    sec_inc = 1'b0;
    min_inc = 1'b0;
    case (state_q)
      ST_RUN: begin
        sec_inc = tick_1hz;
        min_inc = sec_carry;
        if (btn_pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_pause) state_d = ST_RUN;
      end
      ST_ADJUST: begin
        sec_inc = tick_adj && !adj_sel[0];
        min_inc = tick_adj && adj_sel[0];
        state_d = ST_PAUSE;
      end
      default: state_d = ST_PAUSE;
    endcase
    if (adj) state_d = ST_ADJUST;
  end

  bcd_mod60 #(.W(DIGIT_W), .MAX_VAL(MAX_VAL)) u_sec (
    .clk       (clk),
    .rst_n     (btn_reset),
    .inc       (sec_inc),
    .clear     (1'b0),
    .tens      (sec_l),
    .ones      (sec_r),
    .carry_out (sec_carry)
  );

  // Minute wrap at 59:59 is silent; its carry is intentionally dropped.
  bcd_mod60 #(.W(DIGIT_W), .MAX_VAL(MAX_VAL)) u_min (
    .clk       (clk),
    .rst_n     (btn_reset),
    .inc       (min_inc),
    .clear     (1'b0),
    .tens      (min_l),
    .ones      (min_r),
    .carry_out (min_carry)
  );

  logic unused_carry;
  assign unused_carry = min_carry;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter.
module tb_stopwatch_counter;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         btn_reset = 1'b0;
  logic         tick_1hz = 1'b0;
  logic         tick_adj = 1'b0;
  logic         btn_pause = 1'b0;
  logic         adj = 1'b0;
  logic [2:0]   adj_sel = 3'b000;
  logic [W-1:0] min_l, min_r, sec_l, sec_r;
  logic         running;

  int checks = 0;
  int failures = 0;

  stopwatch_counter dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .tick_1hz  (tick_1hz),
    .tick_adj  (tick_adj),
    .btn_pause (btn_pause),
    .adj       (adj),
    .adj_sel   (adj_sel),
    .min_l     (min_l),
    .min_r     (min_r),
    .sec_l     (sec_l),
    .sec_r     (sec_r),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mmss(input int mm, input int ss);
    logic [19:0] v;
    v = {5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10)};
    return 32'(v);
  endfunction

  function automatic logic [31:0] digits();
    return 32'({min_l, min_r, sec_l, sec_r});
  endfunction

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_1hz = 1'b1;
      @(negedge clk) tick_1hz = 1'b0;
    end
  endtask

  // tick_1hz is raised alongside tick_adj when with_1hz is set; adjust must ignore it.
  task automatic tick_a(input int n, input bit with_1hz);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) begin tick_adj = 1'b1; tick_1hz = with_1hz; end
      @(negedge clk) begin tick_adj = 1'b0; tick_1hz = 1'b0; end
    end
  endtask

  task automatic pause_pulse();
    @(negedge clk) btn_pause = 1'b1;
    @(negedge clk) btn_pause = 1'b0;
  endtask

  task automatic set_adj(input logic a, input logic [2:0] sel);
    @(negedge clk) begin adj = a; adj_sel = sel; end
    @(negedge clk);
  endtask

  initial begin
    // Reset held low
    repeat (3) @(negedge clk);
    chk("reset_digits", digits(), mmss(0, 0));
    chk("reset_running", 32'(running), 32'd0);
    btn_reset = 1'b1;

    // Tick after reset is ignored until resumed
    tick1(1);
    chk("post_reset_tick", digits(), mmss(0, 0));
    pause_pulse();
    chk("resume_running", 32'(running), 32'd1);
    tick1(61);
    chk("count_61", digits(), mmss(1, 1));
    chk("count_61_running", 32'(running), 32'd1);

    // Preload 59:58 and roll over
    set_adj(1'b1, 3'b001);
    tick_a(58, 1'b0);
    set_adj(1'b1, 3'b000);
    tick_a(57, 1'b0);
    chk("preload", digits(), mmss(59, 58));
    set_adj(1'b0, 3'b000);
    chk("exit_adj_paused", 32'(running), 32'd0);
    pause_pulse();
    tick1(1);
    chk("at_5959", digits(), mmss(59, 59));
    tick1(1);
    chk("wrap_0000", digits(), mmss(0, 0));

    // Pause holds the count
    tick1(5);
    chk("run_5", digits(), mmss(0, 5));
    pause_pulse();
    chk("paused_running", 32'(running), 32'd0);
    tick1(10);
    chk("paused_hold", digits(), mmss(0, 5));
    pause_pulse();
    tick1(1);
    chk("resume_6", digits(), mmss(0, 6));

    // Adjust: minutes only, upper select bits ignored, 1 Hz ticks ignored
    set_adj(1'b1, 3'b011);
    chk("adj_running", 32'(running), 32'd0);
    tick_a(61, 1'b1);
    chk("adj_min_61", digits(), mmss(1, 6));
    tick1(3);
    chk("adj_ignore_1hz", digits(), mmss(1, 6));
    pause_pulse();
    chk("adj_over_pause", 32'(running), 32'd0);
    set_adj(1'b1, 3'b110);
    tick_a(60, 1'b1);
    chk("adj_sec_60", digits(), mmss(1, 6));
    tick_a(1, 1'b0);
    chk("adj_sec_1", digits(), mmss(1, 7));

    // Move to 00:09 then tick and pause together
    set_adj(1'b1, 3'b001);
    tick_a(59, 1'b0);
    set_adj(1'b1, 3'b000);
    tick_a(2, 1'b0);
    chk("preload_0009", digits(), mmss(0, 9));
    set_adj(1'b0, 3'b000);
    pause_pulse();
    chk("run_0009", 32'(running), 32'd1);
    @(negedge clk) begin tick_1hz = 1'b1; btn_pause = 1'b1; end
    @(negedge clk) begin tick_1hz = 1'b0; btn_pause = 1'b0; end
    chk("tick_and_pause", digits(), mmss(0, 10));
    chk("tick_and_pause_state", 32'(running), 32'd0);

    // Asynchronous reset mid-count at 12:34
    set_adj(1'b1, 3'b001);
    tick_a(12, 1'b0);
    set_adj(1'b1, 3'b000);
    tick_a(24, 1'b0);
    set_adj(1'b0, 3'b000);
    pause_pulse();
    chk("preload_1234", digits(), mmss(12, 34));
    chk("run_1234", 32'(running), 32'd1);
    @(posedge clk);
    #2 btn_reset = 1'b0;
    #1;
    chk("async_reset_digits", digits(), mmss(0, 0));
    chk("async_reset_running", 32'(running), 32'd0);
    tick1(2);
    chk("reset_held", digits(), mmss(0, 0));
    @(negedge clk) btn_reset = 1'b1;
    tick1(1);
    chk("after_reset_tick", digits(), mmss(0, 0));
    pause_pulse();
    tick1(1);
    chk("after_reset_resume", digits(), mmss(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timekeeping core of the stopwatch; sits directly upstream of the display block.
- Produces the four BCD digit registers min_l, min_r, sec_l, sec_r that the display multiplexes onto the 7-segment panel.
- Counts MM:SS on 1 Hz ticks, supports pause/resume, and supports manual adjust of minutes or seconds on the adjust-rate tick.

Parameters:
- DIGIT_W, 5, width of each digit output; matches the display digit inputs.
- MAX_VAL, 59, highest value of each two-digit field (BCD 5/9 ceiling).

Ports:
- clk  input  1  system clock.
- btn_reset  input  1  asynchronous, active-low reset.
- tick_1hz  input  1  single-clk-cycle pulse at 1 Hz, derived from the clkdiv 1 Hz output.
- tick_adj  input  1  single-clk-cycle pulse at the adjust rate, derived from the clkdiv adjust output.
- btn_pause  input  1  debounced single-cycle pulse; toggles run/pause.
- adj  input  1  level; 1 = adjust mode.
- adj_sel  input  3  bit0 selects the field to adjust: 0 = seconds, 1 = minutes. Bits [2:1] are ignored.
- min_l  output  DIGIT_W  minutes tens digit, 0..5.
- min_r  output  DIGIT_W  minutes ones digit, 0..9.
- sec_l  output  DIGIT_W  seconds tens digit, 0..5.
- sec_r  output  DIGIT_W  seconds ones digit, 0..9.
- running  output  1  1 when state is RUN.

Behaviour:
- Reset (btn_reset=0, asynchronous): all digits = 0, state = PAUSE, running = 0. Digits hold 0 while reset is asserted.
- States (2-bit encoding):
  - RUN: count on tick_1hz.
  - PAUSE: hold digits.
  - ADJUST: count only the selected field, on tick_adj.
- Transitions, evaluated on each clk rising edge:
  - Any state with adj=1 -> ADJUST. Adjust has priority over btn_pause.
  - ADJUST with adj=0 -> PAUSE.
  - RUN with btn_pause -> PAUSE.
  - PAUSE with btn_pause -> RUN.
- All outputs are registered. A digit update is visible on the cycle after the tick edge (latency 1 clk).
- RUN counting:
  - On tick_1hz, sec_r increments.
  - sec_r 9 -> 0 carries into sec_l.
  - sec_l:sec_r 59 -> 00 carries into min_r.
  - min_r 9 -> 0 carries into min_l.
  - 59:59 -> 00:00 wraps silently; there is no overflow flag.
  - All carries complete in the same cycle.
- ADJUST counting:
  - On tick_adj, the selected field increments modulo 60 (59 -> 00).
  - No carry into the other field; the unselected field holds.
  - tick_1hz is ignored.
- Simultaneous events:
  - tick_1hz in the same cycle as btn_pause while in RUN: the tick is counted and the state moves to PAUSE. The tick is qualified by the current state, not the next.
  - tick_1hz and tick_adj in the same cycle: only the tick belonging to the current state acts.
  - adj_sel changing mid-adjust takes effect at the next tick_adj.
- Invariant: digits never leave their legal ranges (tens 0..5, ones 0..9). Upper bits of each DIGIT_W output are always 0.
- Reset asserted mid-count or mid-adjust: immediate clear to 00:00 in PAUSE. After reset deasserts, the first tick_1hz does not count until btn_pause is received.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants ST_RUN, ST_PAUSE, ST_ADJUST;
  - BCD limits ONES_MAX=9, TENS_MAX=5;
  - DIGIT_W.
- Sub-module bcd_mod60:
  - Two-digit BCD field with inputs inc and clear, and outputs tens, ones and carry_out (asserted when inc at 59).
  - Instantiated twice, for seconds and minutes.
- Top-level logic: FSM, inc steering (RUN: seconds inc = tick_1hz, minutes inc = seconds carry; ADJUST: inc = tick_adj to the selected field only, carry ignored).

Test Plan:
- Reset, then btn_pause, then 61 tick_1hz -> digits 01:01, running=1.
- Preload to 59:58 via adjust, exit adjust, resume, then 2 tick_1hz -> 00:00, with 59:59 visible after the first tick.
- In RUN, 5 ticks, btn_pause, then 10 ticks -> 00:05 held and running=0; a second btn_pause plus 1 tick -> 00:06.
- adj=1, adj_sel=1, 61 tick_adj -> minutes 01 and seconds unchanged; adj_sel=0, 60 tick_adj -> seconds back to the starting value; tick_1hz is ignored throughout.
- tick_1hz and btn_pause in the same cycle from 00:09 in RUN -> 00:10 and state PAUSE on the next cycle.
- btn_reset pulled low asynchronously mid-cycle at 12:34 -> all digits 0 and running=0 before the next clk edge; they stay 0 until btn_pause and a tick.
